// File: rtl/wb_flop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_flop_pkg
//  Description : Shared constants and helpers for the elastic flop pipeline.
//                DEFAULT_WIDTH / DEFAULT_DEPTH  - default bank geometry
//                clog2_cnt(depth)               - bits needed to hold a
//                                                 population count 0..depth
//  Revision    : 1.0  initial release
// ============================================================================
package wb_flop_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Width of a counter that must represent every value from 0 to depth
    // inclusive; never narrower than one bit.
    function automatic int clog2_cnt(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_if
//  Description : Valid/ready stream bundle around a dff_pipe bank.
//                in_valid/in_ready/in_data    - upstream handshake
//                out_valid/out_ready/out_data - downstream handshake
//                count                        - occupied stage count
//                master : the side that feeds and drains the pipeline
//                slave  : the pipeline itself
//  Revision    : 1.0  initial release
// ============================================================================
interface dff_pipe_if #(
    parameter int WIDTH = wb_flop_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = wb_flop_pkg::DEFAULT_DEPTH
);
    import wb_flop_pkg::*;

    localparam int CNT_W = clog2_cnt(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_stage
//  Description : One elastic stage: a valid bit plus an enable-gated data
//                register.
//                clk    in  clock, rising edge
//                clear  in  synchronous flush (reset or clr)
//                load   in  capture d_in and become valid
//                drain  in  current word leaves this stage
//                d_in   in  WIDTH  incoming word
//                valid  out stage occupied
//                d_out  out WIDTH  held word
//  Revision    : 1.0  initial release
// ============================================================================
module dff_pipe_stage
    import wb_flop_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               RST_DATA = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             clear,
    input  wire logic             load,
    input  wire logic             drain,
    input  wire logic [WIDTH-1:0] d_in,
    output logic                  valid,
    output logic [WIDTH-1:0]      d_out
);

    // A load in the same cycle as a drain keeps the stage occupied: the
    // outgoing word is replaced by the incoming one.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    if (RST_DATA) begin : g_rst_data
        always_ff @(posedge clk) begin
            if (clear) begin
                d_out <= RST_VAL;
            end else if (load) begin
                d_out <= d_in;
            end
        end
    end else begin : g_hold_data
        // No reset value: the register only ever changes on a real load,
        // and a flush cycle suppresses loads so the old word is kept.
        always_ff @(posedge clk) begin
            if (load && !clear) begin
                d_out <= d_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : DEPTH-stage, WIDTH-bit elastic register pipeline with
//                valid/ready flow control and bubble collapse.
//                clk    in  clock, rising edge
//                rst_n  in  synchronous active-low reset
//                en     in  global enable, 0 freezes all state
//                clr    in  synchronous flush, active-high
//                pipe   slave side of dff_pipe_if (handshakes + count)
//                Stage 0 is the input side, stage DEPTH-1 drives out_data.
//  Revision    : 1.0  initial release
// ============================================================================
module dff_pipe
    import wb_flop_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter int               DEPTH    = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               RST_DATA = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  wire logic clr,
    dff_pipe_if.slave pipe
);

    localparam int               CNT_W   = clog2_cnt(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             go;
    logic             flush;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             room;
    logic             in_ready_c;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] count_r;

    // Reset must also silence the handshakes, so it gates movement the
    // same way en does.
    assign go    = en & rst_n;
    assign flush = ~rst_n | clr;

    // Ready chain, evaluated from the output side back to the input.
    // 'room' is "the stage downstream of i will be free after this edge":
    // out_ready for the last stage, otherwise ~v[i+1] | adv[i+1].
    always_comb begin
        adv  = '0;
        room = pipe.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = go & v[i] & room;
            room   = ~v[i] | adv[i];
        end
    end

    assign in_ready_c = go & ~clr & room;
    assign in_fire    = pipe.in_valid & in_ready_c;
    assign out_fire   = adv[DEPTH-1];

    // A stage advancing is exactly its successor loading.
    always_comb begin
        load    = '0;
        load[0] = in_fire;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] d_in;

        if (gi == 0) begin : g_head
            assign d_in = pipe.in_data;
        end else begin : g_body
            assign d_in = d[gi-1];
        end

        dff_pipe_stage #(
            .WIDTH    (WIDTH),
            .RST_VAL  (RST_VAL),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk   (clk),
            .clear (flush),
            .load  (load[gi]),
            .drain (adv[gi]),
            .d_in  (d_in),
            .valid (v[gi]),
            .d_out (d[gi])
        );
    end

    // Occupancy tracks transfers rather than re-counting v[], so it stays a
    // plain up/down register.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_r <= '0;
        end else if (in_fire && !out_fire) begin
            count_r <= count_r + CNT_ONE;
        end else if (!in_fire && out_fire) begin
            count_r <= count_r - CNT_ONE;
        end
    end

    assign pipe.in_ready  = in_ready_c;
    assign pipe.out_valid = go & v[DEPTH-1];
    assign pipe.out_data  = d[DEPTH-1];
    assign pipe.count     = count_r;

endmodule
`default_nettype wire
